// File: rtl/t05_histogram_rmw.sv
// Symbol histogram with read-modify-write counters in an external single-port SRAM.
// An optional clear sweep runs at start. Counters saturate at all-ones.
// Every output is a register loaded from the next-state decode, so it lines up with the state it belongs to.
module t05_histogram_rmw #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TOT_W  = 32,
  parameter int unsigned RD_LAT = 2,
  parameter logic [DATA_W-1:0] EOF_SYM = DATA_W'(8'h1A)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] sram_addr,
  output logic [CNT_W-1:0]  sram_wdata,
  output logic              sram_ren,
  output logic              sram_wen,
  input  logic [CNT_W-1:0]  sram_rdata,
  output logic              busy,
  output logic              eof,
  output logic              done,
  output logic [TOT_W-1:0]  total,
  output logic              sat
);

  // The wait counter only has to reach RD_LAT-1, and RD_LAT is at most 7.
  localparam int unsigned LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ACCEPT = 3'd2,
    S_RD     = 3'd3,
    S_WAIT   = 3'd4,
    S_WR     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   bin, bin_d;
  logic [CNT_W-1:0]    cap, cap_d;
  logic [DATA_W-1:0]   clr_cnt, clr_cnt_d;
  logic [LAT_W-1:0]    wait_cnt, wait_cnt_d;
  logic [TOT_W-1:0]    total_d;
  logic                sat_d;
  logic                eof_d;
  logic                in_ready_d;
  logic [DATA_W-1:0]   sram_addr_d;
  logic [CNT_W-1:0]    sram_wdata_d;
  logic                sram_ren_d;
  logic                sram_wen_d;
  logic                busy_d;
  logic                done_d;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bin        <= '0;
      cap        <= '0;
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      total      <= '0;
      sat        <= 1'b0;
      eof        <= 1'b0;
      in_ready   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ren   <= 1'b0;
      sram_wen   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      bin        <= bin_d;
      cap        <= cap_d;
      clr_cnt    <= clr_cnt_d;
      wait_cnt   <= wait_cnt_d;
      total      <= total_d;
      sat        <= sat_d;
      eof        <= eof_d;
      in_ready   <= in_ready_d;
      sram_addr  <= sram_addr_d;
      sram_wdata <= sram_wdata_d;
      sram_ren   <= sram_ren_d;
      sram_wen   <= sram_wen_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state logic, then output decode of the next state.
  always_comb begin
    state_d      = state;
    bin_d        = bin;
    cap_d        = cap;
    clr_cnt_d    = clr_cnt;
    wait_cnt_d   = wait_cnt;
    total_d      = total;
    sat_d        = sat;
    eof_d        = eof;
    in_ready_d   = 1'b0;
    sram_addr_d  = '0;
    sram_wdata_d = '0;
    sram_ren_d   = 1'b0;
    sram_wen_d   = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          total_d   = '0;
          sat_d     = 1'b0;
          eof_d     = 1'b0;
          clr_cnt_d = '0;
          state_d   = clear_en ? S_CLEAR : S_ACCEPT;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == '1) begin
          state_d = S_ACCEPT;
        end else begin
          clr_cnt_d = clr_cnt + DATA_W'(1);
        end
      end
      S_ACCEPT: begin
        if (in_valid && in_ready) begin
          bin_d   = in_data;
          total_d = total + TOT_W'(1);
          state_d = S_RD;
        end
      end
      S_RD: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Read data is valid exactly on the last wait cycle.
        if (wait_cnt == LAT_W'(RD_LAT - 1)) begin
          cap_d   = sram_rdata;
          state_d = S_WR;
        end else begin
          wait_cnt_d = wait_cnt + LAT_W'(1);
        end
      end
      S_WR: begin
        if (cap == '1) begin
          sat_d = 1'b1;
        end
        if (bin == EOF_SYM) begin
          eof_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    in_ready_d = (state_d == S_ACCEPT);
    sram_ren_d = (state_d == S_RD);
    sram_wen_d = (state_d == S_CLEAR) || (state_d == S_WR);

    case (state_d)
      S_CLEAR:          sram_addr_d = clr_cnt_d;
      S_RD, S_WAIT:     sram_addr_d = bin_d;
      S_WR:             sram_addr_d = bin_d;
      default:          sram_addr_d = '0;
    endcase

    // Increment the captured count, holding at all-ones.
    if (state_d == S_WR) begin
      sram_wdata_d = (cap_d == '1) ? cap_d : cap_d + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_t05_histogram_rmw.sv
// Directed bench for t05_histogram_rmw: one DUT at RD_LAT=2 and one at RD_LAT=3, each with its own SRAM model.
module tb_t05_histogram_rmw;

  logic        clk;
  logic        rst;
  logic        clear_en;

  logic        start_a, in_valid_a, in_ready_a, ren_a, wen_a, busy_a, eof_a, done_a, sat_a;
  logic [7:0]  in_data_a, addr_a;
  logic [31:0] wdata_a, rdata_a, total_a;

  logic        start_b, in_valid_b, in_ready_b, ren_b, wen_b, busy_b, eof_b, done_b, sat_b;
  logic [7:0]  in_data_b, addr_b;
  logic [31:0] wdata_b, rdata_b, total_b;

  logic        pre_we_a, pre_we_b;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] pipe_a [8];
  logic [31:0] pipe_b [8];
  int          lat_a, lat_b;

  logic [39:0] wlog_a [$];
  logic [39:0] wlog_b [$];
  int          hs_a [$];
  int          hs_b [$];
  int          cyc;
  int          conflicts;

  int          n_checks;
  int          n_errors;

  t05_histogram_rmw u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear_en(clear_en),
    .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
    .sram_addr(addr_a), .sram_wdata(wdata_a), .sram_ren(ren_a), .sram_wen(wen_a),
    .sram_rdata(rdata_a), .busy(busy_a), .eof(eof_a), .done(done_a),
    .total(total_a), .sat(sat_a)
  );

  t05_histogram_rmw #(.RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear_en(clear_en),
    .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .sram_addr(addr_b), .sram_wdata(wdata_b), .sram_ren(ren_b), .sram_wen(wen_b),
    .sram_rdata(rdata_b), .busy(busy_b), .eof(eof_b), .done(done_b),
    .total(total_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: read data appears lat cycles after the ren cycle; zero when no read was issued.
  assign rdata_a = pipe_a[3'(lat_a - 1)];
  assign rdata_b = pipe_b[3'(lat_b - 1)];

  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_addr] <= pre_data;
    else if (wen_a) mem_a[addr_a] <= wdata_a;
    pipe_a[0] <= ren_a ? mem_a[addr_a] : 32'h0;
    for (int i = 1; i < 8; i++) pipe_a[i] <= pipe_a[i-1];
    if (pre_we_b) mem_b[pre_addr] <= pre_data;
    else if (wen_b) mem_b[addr_b] <= wdata_b;
    pipe_b[0] <= ren_b ? mem_b[addr_b] : 32'h0;
    for (int i = 1; i < 8; i++) pipe_b[i] <= pipe_b[i-1];
  end

  // Bus monitor: write log, handshake times, strobe conflicts.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wen_a) wlog_a.push_back({addr_a, wdata_a});
    if (wen_b) wlog_b.push_back({addr_b, wdata_b});
    if (in_valid_a && in_ready_a) hs_a.push_back(cyc);
    if (in_valid_b && in_ready_b) hs_b.push_back(cyc);
    if ((ren_a && wen_a) || (ren_b && wen_b)) conflicts <= conflicts + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_flags"}, 64'({in_ready_a, busy_a, eof_a, done_a, sat_a, ren_a, wen_a}), 64'd0);
    check({tag, "_bus"}, 64'({addr_a, wdata_a}), 64'd0);
    check({tag, "_total"}, 64'(total_a), 64'd0);
  endtask

  task automatic preload(input bit sel, input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    if (sel) pre_we_b = 1'b1; else pre_we_a = 1'b1;
    @(negedge clk);
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  task automatic pulse_start(input bit sel, input logic clr);
    clear_en = clr;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    start_b  = 1'b0;
    clear_en = 1'b0;
  endtask

  // Present one symbol and return on the negedge after its handshake; in_valid is left high.
  task automatic send(input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    if (sel) begin in_valid_b = 1'b1; in_data_b = d; end
    else     begin in_valid_a = 1'b1; in_data_a = d; end
    while (!(sel ? in_ready_b : in_ready_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("hs_timeout", 64'(sel ? in_ready_b : in_ready_a), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? done_b : done_a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("done_timeout", 64'(sel ? done_b : done_a), 64'd1);
  endtask

  // Clear sweep on DUT A: 256 zero writes at ascending addresses, busy throughout.
  task automatic run_clear();
    int n, bad, w0, cnt;
    w0 = wlog_a.size();
    pulse_start(1'b0, 1'b1);
    n = 0;
    bad = 0;
    while (!in_ready_a && n < 400) begin
      if (!busy_a) bad++;
      n++;
      @(negedge clk);
    end
    check("clear_cycles", 64'(n), 64'd256);
    check("clear_busy", 64'(bad), 64'd0);
    check("clear_ready_busy", 64'({in_ready_a, busy_a}), 64'b11);
    cnt = wlog_a.size() - w0;
    check("clear_writes", 64'(cnt), 64'd256);
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (wlog_a[w0+i] !== {8'(i), 32'h0}) bad++;
    end
    check("clear_addr_data", 64'(bad), 64'd0);
  endtask

  initial begin
    int w, h;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    clear_en   = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    in_data_a  = 8'h0;
    in_data_b  = 8'h0;
    pre_we_a   = 1'b0;
    pre_we_b   = 1'b0;
    pre_addr   = 8'h0;
    pre_data   = 32'h0;
    lat_a      = 2;
    lat_b      = 3;

    repeat (2) @(negedge clk);
    check_idle_a("reset");
    rst = 1'b1;
    @(negedge clk);

    // Clear sweep from IDLE.
    run_clear();

    // Stream A,B,A,EOF with in_valid held high.
    w = wlog_a.size();
    h = hs_a.size();
    send(1'b0, 8'h41);
    send(1'b0, 8'h42);
    send(1'b0, 8'h41);
    send(1'b0, 8'h1A);
    in_valid_a = 1'b0;
    wait_done(1'b0);
    check("s2_nwrites", 64'(wlog_a.size() - w), 64'd4);
    check("s2_w0", 64'(wlog_a[w]),   64'({8'h41, 32'd1}));
    check("s2_w1", 64'(wlog_a[w+1]), 64'({8'h42, 32'd1}));
    check("s2_w2", 64'(wlog_a[w+2]), 64'({8'h41, 32'd2}));
    check("s2_w3", 64'(wlog_a[w+3]), 64'({8'h1A, 32'd1}));
    for (int k = 0; k < 3; k++) check("s2_hs_gap", 64'(hs_a[h+k+1] - hs_a[h+k]), 64'd5);
    check("s2_flags", 64'({eof_a, done_a, busy_a, sat_a}), 64'b1100);
    check("s2_total", 64'(total_a), 64'd4);

    // Symbols offered in DONE are refused.
    h = hs_a.size();
    in_valid_a = 1'b1;
    in_data_a  = 8'h43;
    repeat (3) @(negedge clk);
    check("done_ready", 64'(in_ready_a), 64'd0);
    check("done_no_hs", 64'(hs_a.size() - h), 64'd0);
    check("done_total", 64'(total_a), 64'd4);
    in_valid_a = 1'b0;

    // Saturation: bin 0x41 preloaded to all-ones, no clear.
    preload(1'b0, 8'h41, 32'hFFFF_FFFF);
    w = wlog_a.size();
    pulse_start(1'b0, 1'b0);
    check("s3_start_clears", 64'({total_a, eof_a, done_a}), 64'd0);
    send(1'b0, 8'h41);
    send(1'b0, 8'h1A);
    in_valid_a = 1'b0;
    wait_done(1'b0);
    check("s3_w0", 64'(wlog_a[w]),   64'({8'h41, 32'hFFFF_FFFF}));
    check("s3_w1", 64'(wlog_a[w+1]), 64'({8'h1A, 32'd2}));
    check("s3_sat", 64'(sat_a), 64'd1);
    check("s3_total", 64'(total_a), 64'd2);

    // RD_LAT=3 with exact model latency.
    preload(1'b1, 8'h10, 32'd5);
    preload(1'b1, 8'h1A, 32'd7);
    w = wlog_b.size();
    h = hs_b.size();
    pulse_start(1'b1, 1'b0);
    send(1'b1, 8'h10);
    send(1'b1, 8'h1A);
    in_valid_b = 1'b0;
    wait_done(1'b1);
    check("s4_w0", 64'(wlog_b[w]),   64'({8'h10, 32'd6}));
    check("s4_w1", 64'(wlog_b[w+1]), 64'({8'h1A, 32'd8}));
    check("s4_hs_gap", 64'(hs_b[h+1] - hs_b[h]), 64'd6);
    check("s4_total_eof", 64'({total_b, eof_b, sat_b}), 64'({32'd2, 2'b10}));

    // Model one cycle late: the capture picks up the idle zero, so a wrong count is written.
    lat_b = 4;
    preload(1'b1, 8'h20, 32'd9);
    w = wlog_b.size();
    pulse_start(1'b1, 1'b0);
    send(1'b1, 8'h20);
    send(1'b1, 8'h1A);
    in_valid_b = 1'b0;
    wait_done(1'b1);
    check("s4_late_w0", 64'(wlog_b[w]),   64'({8'h20, 32'd1}));
    check("s4_late_w1", 64'(wlog_b[w+1]), 64'({8'h1A, 32'd1}));

    // Valid gaps and a start pulse during WAIT.
    w = wlog_a.size();
    h = hs_a.size();
    pulse_start(1'b0, 1'b0);
    check("s5_start_clears_sat", 64'(sat_a), 64'd0);
    repeat (3) @(negedge clk);
    check("s5_gap_ready", 64'(in_ready_a), 64'd1);
    check("s5_gap_total", 64'(total_a), 64'd0);
    send(1'b0, 8'h42);
    in_valid_a = 1'b0;
    @(negedge clk);
    pulse_start(1'b0, 1'b1);
    check("s5_start_ignored", 64'({busy_a, in_ready_a, total_a}), 64'({2'b10, 32'd1}));
    repeat (4) @(negedge clk);
    check("s5_back_to_accept", 64'({in_ready_a, busy_a}), 64'b11);
    send(1'b0, 8'h1A);
    in_valid_a = 1'b0;
    wait_done(1'b0);
    check("s5_nwrites", 64'(wlog_a.size() - w), 64'd2);
    check("s5_w0", 64'(wlog_a[w]),   64'({8'h42, 32'd2}));
    check("s5_w1", 64'(wlog_a[w+1]), 64'({8'h1A, 32'd3}));
    check("s5_hs_count", 64'(hs_a.size() - h), 64'd2);
    check("s5_total", 64'(total_a), 64'd2);

    // Reset in the middle of WAIT.
    pulse_start(1'b0, 1'b0);
    send(1'b0, 8'h41);
    in_valid_a = 1'b0;
    @(negedge clk);
    w = wlog_a.size();
    rst = 1'b0;
    #1;
    check_idle_a("rst_wait");
    @(negedge clk);
    check_idle_a("rst_hold");
    check("rst_no_write", 64'(wlog_a.size() - w), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    run_clear();
    w = wlog_a.size();
    send(1'b0, 8'h41);
    send(1'b0, 8'h1A);
    in_valid_a = 1'b0;
    wait_done(1'b0);
    check("s6_w0", 64'(wlog_a[w]),   64'({8'h41, 32'd1}));
    check("s6_w1", 64'(wlog_a[w+1]), 64'({8'h1A, 32'd1}));
    check("s6_state", 64'({total_a, sat_a, eof_a, done_a}), 64'({32'd2, 3'b011}));

    check("ren_wen_conflicts", 64'(conflicts), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/t05_histogram_rmw.md
Name: t05_histogram_rmw

Overview:
Parametrised successor to the team's byte histogram. Accepts a symbol stream over a valid/ready handshake and keeps one count per symbol value in an external single-port SRAM, using a read-modify-write per symbol. Adds a configurable symbol width, count width and SRAM read latency, an optional clear-all sweep at start, and saturating counters. Sits between the SPI byte front-end and the shared SRAM arbiter. Results are reported to the controller through busy/eof/done/total.

Parameters:
DATA_W, 8, symbol width; bin count NBINS = 2**DATA_W; SRAM address width = DATA_W
CNT_W, 32, bin counter width and SRAM data width
TOT_W, 32, width of the total-symbol counter
RD_LAT, 2, SRAM read latency in cycles, legal range 1..7
EOF_SYM, 8'h1A, terminating symbol, DATA_W bits

Ports:
clk  in  1  clock, all state changes on the rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a run; ignored unless in IDLE or DONE
clear_en  in  1  sampled with start; 1 = zero all bins before accepting symbols
in_valid  in  1  symbol valid
in_data  in  DATA_W  symbol
in_ready  out  1  block can take a symbol; transfer occurs when in_valid & in_ready
sram_addr  out  DATA_W  bin address
sram_wdata  out  CNT_W  write data
sram_ren  out  1  read strobe, one cycle
sram_wen  out  1  write strobe, one cycle
sram_rdata  in  CNT_W  read data, valid RD_LAT cycles after the sram_ren cycle
busy  out  1  high in every state except IDLE and DONE
eof  out  1  high from the WR of EOF_SYM until the next start
done  out  1  high in DONE
total  out  TOT_W  symbols accepted in the current run, EOF_SYM included
sat  out  1  sticky; set if any bin increment saturated in this run

Behaviour:
- Reset (rst=0, asynchronous) sets state=IDLE and drives all outputs to 0. The bin index, capture register and clear counter also go to 0. SRAM contents are not touched and are undefined after a reset in mid-run.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid or sram_rdata to any output.
- State IDLE / DONE, on start: clear total, sat and eof. If clear_en=1, go to CLEAR; otherwise go to ACCEPT.
- State CLEAR: sram_wen=1, sram_wdata=0, sram_addr=clr_cnt. clr_cnt runs 0..NBINS-1, one address per cycle, NBINS cycles in total. After address NBINS-1, go to ACCEPT. in_ready stays 0 throughout.
- State ACCEPT: in_ready=1. On handshake, latch in_data into bin, set total = total+1 (wraps modulo 2**TOT_W), and go to RD. With no handshake, stay in ACCEPT.
- State RD: one cycle; sram_ren=1, sram_addr=bin. Then go to WAIT.
- State WAIT: counter runs for exactly RD_LAT cycles. sram_addr holds bin, and both strobes are 0. On the last WAIT cycle, capture sram_rdata. Then go to WR.
- State WR: one cycle; sram_wen=1, sram_addr=bin, sram_wdata = captured+1.
  - If captured equals all-ones, write all-ones instead and set sat.
  - If bin==EOF_SYM, set eof and go to DONE; otherwise go to ACCEPT.
- Throughput: RD_LAT+3 cycles per symbol, handshake cycle included. Only one symbol is in flight, so there is no address hazard.
- DONE: done=1, and total and eof hold until the next start. Symbols presented in DONE are not accepted (in_ready=0).
- sram_ren and sram_wen are never high in the same cycle.
- A start pulse while busy=1 is ignored and causes no state change.
- in_valid held high with in_ready=0 is legal. The source must hold in_data stable until the handshake.

Test Plan:
1. Defaults, start with clear_en=1 -> exactly 256 CLEAR write cycles at addresses 0..255 with wdata=0. in_ready rises the next cycle. busy=1 throughout.
2. Stream 'A','B','A',0x1A with in_valid held high -> writes: bin 0x41=1, 0x42=1, 0x41=2, 0x1A=1. Handshakes are 5 cycles apart. Then eof=1, done=1, total=4.
3. Preload bin 0x41 with 0xFFFFFFFF, start with clear_en=0, send 'A',0x1A -> bin 0x41 written 0xFFFFFFFF. sat=1, total=2.
4. Set RD_LAT=3 and have the SRAM model return data exactly 3 cycles after sram_ren -> the correct value+1 is written, and the handshake spacing is 6 cycles. Repeat with the data late by 1 cycle: the wrong value is written, proving the capture timing is exact.
5. Gaps in in_valid, plus a start pulse during WAIT -> no state change from the start. Symbols are counted only on handshakes. Never ren&wen in the same cycle.
6. Drop rst low during WAIT, then release -> IDLE with all outputs 0, no SRAM strobes. A new start with clear_en=1 runs normally.
